// File: rtl/eb_pkg.sv
// Shared definitions for the elastic buffer: occupancy state type and the
// helper that sizes the occupancy counter.
package eb_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } eb_state_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage : eb_pkg

// File: rtl/eb_storage.sv
// Register array for the elastic buffer: DEPTH x DATA_WIDTH entries with one
// synchronous write port and one asynchronous read port. Contents need no reset.
//   clock    : rising-edge clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational from i_raddr)
module eb_storage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [PTR_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read port.
    assign o_rdata = r_mem[i_raddr];

endmodule : eb_storage

// File: rtl/elastic_buffer.sv
// Elastic buffer: small FIFO between a valid/ready producer and consumer.
// Occupancy is tracked as EMPTY / PARTIAL / FULL with an explicit count; the
// head entry is presented on io_dout. Also flags upstream withdrawing valid
// before acceptance as a sticky error.
//   clock      : rising-edge clock
//   reset      : synchronous active-low reset
//   io_din     : upstream payload        io_din_v  : upstream valid
//   io_din_r   : ready to upstream
//   io_dout    : head payload            io_dout_v : downstream valid
//   io_dout_r  : downstream ready
//   io_count   : current occupancy       io_err    : sticky protocol error
module elastic_buffer
    import eb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         io_din,
    input  logic                          io_din_v,
    output logic                          io_din_r,
    output logic [DATA_WIDTH-1:0]         io_dout,
    output logic                          io_dout_v,
    input  logic                          io_dout_r,
    output logic [count_width(DEPTH)-1:0] io_count,
    output logic                          io_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    eb_state_e        r_state;
    eb_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_stall;
    logic             r_err;
    logic             w_push;
    logic             w_pop;
    logic             w_din_r;
    logic             w_dout_v;

    // Handshake outputs decoded from registered state only (plus reset gating).
    always_comb begin
        w_din_r  = 1'b0;
        w_dout_v = 1'b0;
        if (reset && (r_state != FULL)) begin
            w_din_r = 1'b1;
        end
        if (r_state != EMPTY) begin
            w_dout_v = 1'b1;
        end
    end

    // Next occupancy and state from this cycle's push/pop.
    always_comb begin
        w_push      = io_din_v & w_din_r;
        w_pop       = w_dout_v & io_dout_r;
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_count_nxt == CNT_W'(0)) begin
            w_state_nxt = EMPTY;
        end else if (w_count_nxt == CNT_W'(DEPTH)) begin
            w_state_nxt = FULL;
        end else begin
            w_state_nxt = PARTIAL;
        end
    end

    // State, pointers, count and error tracker.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_stall <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            // r_stall: valid was offered but refused at the previous edge.
            r_stall <= io_din_v & ~w_din_r;
            r_err   <= r_err | (r_stall & ~io_din_v);
        end
    end

    eb_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_storage (
        .clock   (clock),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (io_din),
        .i_raddr (r_rptr),
        .o_rdata (io_dout)
    );

    assign io_din_r  = w_din_r;
    assign io_dout_v = w_dout_v;
    assign io_count  = r_count;
    assign io_err    = r_err;

endmodule : elastic_buffer

// File: tb/tb_elastic_buffer.sv
// Directed bench for elastic_buffer: a DEPTH=2 instance for fill, full+pop,
// protocol error, reset and pass-through, and a DEPTH=4 instance for wrap-around.
module tb_elastic_buffer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] d2_din;
    logic        d2_din_v;
    logic        d2_din_r;
    logic [31:0] d2_dout;
    logic        d2_dout_v;
    logic        d2_dout_r;
    logic [1:0]  d2_count;
    logic        d2_err;

    logic [31:0] d4_din;
    logic        d4_din_v;
    logic        d4_din_r;
    logic [31:0] d4_dout;
    logic        d4_dout_v;
    logic        d4_dout_r;
    logic [2:0]  d4_count;
    logic        d4_err;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] q[$];
    int          sent;
    int          got;
    int          mcount;
    logic        m_push;
    logic        m_pop;
    logic [15:0] pat;

    always #5 clk = ~clk;

    elastic_buffer #(.DATA_WIDTH(32), .DEPTH(2)) dut2 (
        .clock     (clk),
        .reset     (rst_n),
        .io_din    (d2_din),
        .io_din_v  (d2_din_v),
        .io_din_r  (d2_din_r),
        .io_dout   (d2_dout),
        .io_dout_v (d2_dout_v),
        .io_dout_r (d2_dout_r),
        .io_count  (d2_count),
        .io_err    (d2_err)
    );

    elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut4 (
        .clock     (clk),
        .reset     (rst_n),
        .io_din    (d4_din),
        .io_din_v  (d4_din_v),
        .io_din_r  (d4_din_r),
        .io_dout   (d4_dout),
        .io_dout_v (d4_dout_v),
        .io_dout_r (d4_dout_r),
        .io_count  (d4_count),
        .io_err    (d4_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        d2_din    = '0;
        d2_din_v  = 1'b0;
        d2_dout_r = 1'b0;
        d4_din    = '0;
        d4_din_v  = 1'b0;
        d4_dout_r = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_din_r_low", 32'(d2_din_r), 32'd0);
        chk("rst_count", 32'(d2_count), 32'd0);
        chk("rst_dout_v", 32'(d2_dout_v), 32'd0);
        chk("rst_err", 32'(d2_err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_din_r_high", 32'(d2_din_r), 32'd1);
        chk("rst4_count", 32'(d4_count), 32'd0);

        // Basic fill, no downstream ready
        d2_din_v = 1'b1;
        d2_din   = 32'hA1;
        tick();
        chk("fill1_count", 32'(d2_count), 32'd1);
        chk("fill1_dout_v", 32'(d2_dout_v), 32'd1);
        chk("fill1_dout", d2_dout, 32'hA1);
        d2_din = 32'hB2;
        tick();
        chk("fill2_count", 32'(d2_count), 32'd2);
        chk("fill2_din_r", 32'(d2_din_r), 32'd0);
        chk("fill2_dout", d2_dout, 32'hA1);
        d2_din_v = 1'b0;
        tick();
        chk("fill_hold_dout", d2_dout, 32'hA1);
        chk("fill_hold_count", 32'(d2_count), 32'd2);

        // FULL with push offered and pop: pop only
        d2_din_v  = 1'b1;
        d2_din    = 32'hC3;
        d2_dout_r = 1'b1;
        tick();
        chk("fullpop_count", 32'(d2_count), 32'd1);
        chk("fullpop_dout", d2_dout, 32'hB2);
        chk("fullpop_din_r", 32'(d2_din_r), 32'd1);
        d2_dout_r = 1'b0;
        tick();
        chk("fullpop_push_count", 32'(d2_count), 32'd2);
        d2_din_v  = 1'b0;
        d2_dout_r = 1'b1;
        tick();
        chk("drain1_dout", d2_dout, 32'hC3);
        chk("drain1_count", 32'(d2_count), 32'd1);
        tick();
        chk("drain2_count", 32'(d2_count), 32'd0);
        chk("drain2_dout_v", 32'(d2_dout_v), 32'd0);
        tick();
        chk("underflow_count", 32'(d2_count), 32'd0);
        chk("no_err_yet", 32'(d2_err), 32'd0);

        // Protocol error: valid withdrawn while refused
        d2_dout_r = 1'b0;
        d2_din_v  = 1'b1;
        d2_din    = 32'h11;
        tick();
        d2_din = 32'h22;
        tick();
        d2_din = 32'h33;
        tick();
        chk("perr_full_count", 32'(d2_count), 32'd2);
        chk("perr_not_yet", 32'(d2_err), 32'd0);
        d2_din_v = 1'b0;
        tick();
        chk("perr_set", 32'(d2_err), 32'd1);
        tick();
        chk("perr_sticky", 32'(d2_err), 32'd1);
        chk("perr_dout", d2_dout, 32'h11);

        // Reset mid-stream with two entries stored
        rst_n = 1'b0;
        tick();
        chk("mrst_count", 32'(d2_count), 32'd0);
        chk("mrst_dout_v", 32'(d2_dout_v), 32'd0);
        chk("mrst_err", 32'(d2_err), 32'd0);
        chk("mrst_din_r", 32'(d2_din_r), 32'd0);
        rst_n    = 1'b1;
        d2_din_v = 1'b1;
        d2_din   = 32'h55;
        #1;
        chk("mrst_din_r_back", 32'(d2_din_r), 32'd1);
        tick();
        chk("mrst_push_v", 32'(d2_dout_v), 32'd1);
        chk("mrst_push_dout", d2_dout, 32'h55);
        chk("mrst_push_count", 32'(d2_count), 32'd1);
        d2_din_v  = 1'b0;
        d2_dout_r = 1'b1;
        tick();
        chk("mrst_pop_count", 32'(d2_count), 32'd0);

        // Pass-through stream 1..100
        d2_din_v  = 1'b1;
        d2_dout_r = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            d2_din = 32'(i);
            tick();
            chk("pt_dout", d2_dout, 32'(i));
            chk("pt_count", 32'(d2_count), 32'd1);
        end
        d2_din_v = 1'b0;
        tick();
        chk("pt_end_count", 32'(d2_count), 32'd0);
        chk("pt_end_dout_v", 32'(d2_dout_v), 32'd0);
        chk("pt_err", 32'(d2_err), 32'd0);
        d2_dout_r = 1'b0;

        // Wrap-around on DEPTH=4 with a fixed backpressure pattern
        sent   = 0;
        got    = 0;
        mcount = 0;
        pat    = 16'b1011_0110_1000_0000;
        for (int c = 0; c < 60 && got < 10; c++) begin
            d4_din    = 32'h100 + 32'(sent);
            d4_din_v  = (sent < 10);
            d4_dout_r = pat[c % 16];
            #1;
            chk("wrap_din_r", 32'(d4_din_r), 32'(mcount < 4));
            chk("wrap_dout_v", 32'(d4_dout_v), 32'(mcount > 0));
            if (mcount > 0) begin
                chk("wrap_dout", d4_dout, q[0]);
            end
            m_push = d4_din_v && (mcount < 4);
            m_pop  = (mcount > 0) && d4_dout_r;
            tick();
            if (m_push) begin
                q.push_back(32'h100 + 32'(sent));
                sent++;
                mcount++;
            end
            if (m_pop) begin
                void'(q.pop_front());
                got++;
                mcount--;
            end
            chk("wrap_count", 32'(d4_count), 32'(mcount));
        end
        chk("wrap_got", 32'(got), 32'd10);
        chk("wrap_err", 32'(d4_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_elastic_buffer
